// File: rtl/rll_keyed_pipe.sv
// rll_keyed_pipe: lock key loaded serially over a valid/ready handshake, then
// applied as XOR/XNOR key gates to a DATA_W-bit elastic valid/ready pipeline.
// With the correct key (== KEY_POL) the stream passes through unchanged.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   key_start                   request a new key load (drains stream first)
//   key_valid/key_bit/key_ready serial key bits, LSB first
//   key_done                    one-cycle pulse after the last key bit
//   armed                       key loaded, stream enabled
//   in_valid/in_data/in_ready   input stream
//   out_valid/out_data/out_ready keyed output stream
module rll_keyed_pipe #(
    parameter int unsigned      DATA_W  = 32,
    parameter int unsigned      KEY_W   = 32,
    parameter int unsigned      STAGES  = 2,
    parameter logic [KEY_W-1:0] KEY_POL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start,
    input  logic              key_valid,
    input  logic              key_bit,
    output logic              key_ready,
    output logic              key_done,
    output logic              armed,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int unsigned CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, DRAIN} state_t;

    state_t            state;
    logic [KEY_W-1:0]  key_reg;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mask_c;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv_c;
    logic [DATA_W-1:0] pipe [STAGES];
    logic              accept_c;

    // Key bits repeat across the data word; XNOR polarity folds into the mask.
    for (genvar i = 0; i < DATA_W; i++) begin : g_mask
        assign mask_c[i] = key_reg[i % KEY_W] ^ KEY_POL[i % KEY_W];
    end

    // Stage k may advance if any stage at or after it is empty, or the sink takes a word.
    always_comb begin
        adv_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv_c[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!vld[j]) adv_c[k] = 1'b1;
            end
        end
    end

    // key_start blocks input in the same cycle so nothing enters behind a re-key.
    assign in_ready = (state == ARMED) && !key_start && adv_c[0];
    assign accept_c = in_valid && in_ready;

    // Control FSM and key register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            cnt       <= '0;
            key_ready <= 1'b0;
            key_done  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            key_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_start) begin
                        state     <= LOAD;
                        key_ready <= 1'b1;
                        cnt       <= '0;
                    end
                end
                LOAD: begin
                    if (key_start) begin
                        cnt <= '0;
                    end else if (key_valid) begin
                        key_reg[cnt] <= key_bit;
                        if (cnt == CNT_W'(KEY_W - 1)) begin
                            cnt       <= '0;
                            key_done  <= 1'b1;
                            key_ready <= 1'b0;
                            armed     <= 1'b1;
                            state     <= ARMED;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (key_start) begin
                        state <= DRAIN;
                        armed <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (vld == '0) begin
                        state     <= LOAD;
                        key_ready <= 1'b1;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Elastic pipeline; mask applied only at stage-1 capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
        end else begin
            if (adv_c[0]) begin
                vld[0] <= accept_c;
                if (accept_c) pipe[0] <= in_data ^ mask_c;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv_c[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) pipe[k] <= pipe[k-1];
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_data  = pipe[STAGES-1];

endmodule

// File: tb/tb_rll_keyed_pipe.sv
// Bench for rll_keyed_pipe: three instances (KEY_POL=0/KEY_W=32, KEY_POL=A5A5A5A5,
// KEY_W=8) driven by directed vectors; a monitor pops expected words from
// per-instance queues whenever an output handshake occurs.
module tb_rll_keyed_pipe;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        key_start [3];
    logic        key_valid [3];
    logic        key_bit   [3];
    logic        key_ready [3];
    logic        key_done  [3];
    logic        armed     [3];
    logic        in_valid  [3];
    logic [31:0] in_data   [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] out_data  [3];
    logic        out_ready [3];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rll_keyed_pipe #(.DATA_W(32), .KEY_W(32), .STAGES(2), .KEY_POL(32'h0000_0000)) u0 (
        .clk(clk), .rst(rst[0]), .key_start(key_start[0]), .key_valid(key_valid[0]),
        .key_bit(key_bit[0]), .key_ready(key_ready[0]), .key_done(key_done[0]),
        .armed(armed[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
        .out_ready(out_ready[0]));

    rll_keyed_pipe #(.DATA_W(32), .KEY_W(32), .STAGES(2), .KEY_POL(32'hA5A5_A5A5)) u1 (
        .clk(clk), .rst(rst[1]), .key_start(key_start[1]), .key_valid(key_valid[1]),
        .key_bit(key_bit[1]), .key_ready(key_ready[1]), .key_done(key_done[1]),
        .armed(armed[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
        .out_ready(out_ready[1]));

    rll_keyed_pipe #(.DATA_W(32), .KEY_W(8), .STAGES(2), .KEY_POL(8'h00)) u2 (
        .clk(clk), .rst(rst[2]), .key_start(key_start[2]), .key_valid(key_valid[2]),
        .key_bit(key_bit[2]), .key_ready(key_ready[2]), .key_done(key_done[2]),
        .armed(armed[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_data(out_data[2]),
        .out_ready(out_ready[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t pop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst[d] && out_valid[d] && out_ready[d]) begin
                if (qsize(d) == 0) begin
                    chk($sformatf("unexpected_out_dut%0d", d), out_data[d], 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = pop(d);
                    chk($sformatf("out_data_dut%0d", d), out_data[d], e.data);
                    if (e.lat) chk($sformatf("latency_dut%0d", d), 32'(cyc - e.cyc), 32'(LAT));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_bits(input int d, input logic [31:0] key, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int t;
            t = 0;
            key_valid[d] = 1'b1;
            key_bit[d]   = key[i];
            @(negedge clk);
            while (!key_ready[d] && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk($sformatf("key_ready_timeout_dut%0d", d), 32'(key_ready[d]), 32'd1);
            tick();
        end
        key_valid[d] = 1'b0;
    endtask

    task automatic load_key(input int d, input logic [31:0] key, input int nbits);
        key_start[d] = 1'b1;
        tick();
        key_start[d] = 1'b0;
        feed_bits(d, key, nbits);
        chk($sformatf("key_done_pulse_dut%0d", d), 32'(key_done[d]), 32'd1);
        chk($sformatf("armed_dut%0d", d), 32'(armed[d]), 32'd1);
        tick();
        chk($sformatf("key_done_single_dut%0d", d), 32'(key_done[d]), 32'd0);
    endtask

    task automatic send(input int d, input logic [31:0] data, input logic [31:0] exp,
                        input bit lat, output int acc_cyc);
        int   t;
        exp_t e;
        t = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        @(negedge clk);
        while (!in_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        acc_cyc = cyc;
        if (t >= 50) begin
            chk($sformatf("in_ready_timeout_dut%0d", d), 32'(in_ready[d]), 32'd1);
        end else begin
            e.data = exp;
            e.cyc  = cyc;
            e.lat  = lat;
            push(d, e);
        end
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_empty(input int d);
        int t;
        t = 0;
        while (qsize(d) != 0 && t < 50) begin
            tick();
            t++;
        end
        chk($sformatf("drained_dut%0d", d), 32'(qsize(d)), 32'd0);
    endtask

    logic [31:0] stream [8];
    int          acc;
    int          prev_acc;
    int          t;

    initial begin
        stream[0] = 32'h0000_0000; stream[1] = 32'hFFFF_FFFF;
        stream[2] = 32'h1234_5678; stream[3] = 32'h8765_4321;
        stream[4] = 32'hA5A5_A5A5; stream[5] = 32'h5A5A_5A5A;
        stream[6] = 32'h0F0F_F0F0; stream[7] = 32'hDEAD_BEEF;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; key_start[d] = 1'b0; key_valid[d] = 1'b0; key_bit[d] = 1'b0;
            in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ctrl_dut%0d", d),
                32'({key_ready[d], key_done[d], armed[d], in_ready[d], out_valid[d]}), 32'd0);
            chk($sformatf("reset_data_dut%0d", d), out_data[d], 32'd0);
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        tick();

        // Correct all-zero key: identity, 2-cycle latency.
        load_key(0, 32'h0000_0000, 32);
        send(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, acc);
        wait_empty(0);

        // Wrong key 0xFF flips the low byte.
        load_key(0, 32'h0000_00FF, 32);
        send(0, 32'h1234_5678, 32'h1234_5687, 1'b1, acc);
        wait_empty(0);

        // Re-key with two words in flight: they leave with the old mask.
        send(0, 32'hAAAA_0000, 32'hAAAA_00FF, 1'b1, acc);
        send(0, 32'h0000_5555, 32'h0000_55AA, 1'b1, acc);
        key_start[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("in_ready_on_key_start", 32'(in_ready[0]), 32'd0);
        tick();
        key_start[0] = 1'b0;
        in_valid[0]  = 1'b0;
        t = 0;
        @(negedge clk);
        while (!key_ready[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("key_ready_after_drain", 32'(key_ready[0]), 32'd1);
        chk("drain_before_load", 32'(q0.size()), 32'd0);
        tick();
        load_key(0, 32'h0000_0F00, 32);
        send(0, 32'h1111_1111, 32'h1111_1E11, 1'b1, acc);
        wait_empty(0);

        // XNOR polarity, correct key, 8 words back-to-back.
        load_key(1, 32'hA5A5_A5A5, 32);
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(1, stream[i], stream[i], 1'b1, acc);
            if (i > 0) chk("back_to_back_accept", 32'(acc - prev_acc), 32'd1);
            prev_acc = acc;
        end
        wait_empty(1);

        // Backpressure: full pipe holds steady for 5 cycles, then drains in order.
        out_ready[1] = 1'b0;
        send(1, 32'h0000_0011, 32'h0000_0011, 1'b0, acc);
        send(1, 32'h0000_0022, 32'h0000_0022, 1'b0, acc);
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h0000_0033;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready[1]), 32'd0);
            chk("stall_out_valid", 32'(out_valid[1]), 32'd1);
            chk("stall_out_data", out_data[1], 32'h0000_0011);
            tick();
        end
        out_ready[1] = 1'b1;
        send(1, 32'h0000_0033, 32'h0000_0033, 1'b0, acc);
        wait_empty(1);

        // Short key repeats across the word.
        load_key(2, 32'h0000_0001, 8);
        send(2, 32'h0000_0000, 32'h0101_0101, 1'b1, acc);
        wait_empty(2);

        // Reset while bit 10 of a load is presented.
        key_start[0] = 1'b1;
        tick();
        key_start[0] = 1'b0;
        feed_bits(0, 32'hFFFF_FFFF, 10);
        key_valid[0] = 1'b1;
        key_bit[0]   = 1'b1;
        rst[0]       = 1'b1;
        #1;
        chk("midload_rst_armed", 32'(armed[0]), 32'd0);
        chk("midload_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midload_rst_key_ready", 32'(key_ready[0]), 32'd0);
        tick();
        rst[0]       = 1'b0;
        key_valid[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stream_before_load", 32'(in_ready[0]), 32'd0);
            tick();
        end
        in_valid[0] = 1'b0;
        load_key(0, 32'h0000_0000, 32);
        send(0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, acc);
        wait_empty(0);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rll_keyed_pipe.md
Name: rll_keyed_pipe

Overview:
- Parametrised sequential successor to the team's flat RLL-locked combinational benchmarks.
- Holds a KEY_W-bit lock key, loaded serially through a handshake, in an internal register.
- Applies the key as XOR/XNOR key gates to a DATA_W-bit valid/ready stream.
- The stream passes through a STAGES-deep pipeline. Output equals input only when the loaded key matches the polarity mask; any other key corrupts the corresponding bits.

Parameters:
- DATA_W, 32: stream data width, >=1.
- KEY_W, 32: key length in bits, 1..DATA_W.
- STAGES, 2: pipeline register depth, >=1.
- KEY_POL, 32'h0000_0000 (KEY_W bits): gate polarity per key bit. 1 = XNOR gate, 0 = XOR gate. The correct key equals KEY_POL.

Ports:
- clk  in  1  clock, all flops rising edge
- rst  in  1  asynchronous active-high reset
- key_start  in  1  request a new key load
- key_valid  in  1  key bit valid
- key_bit  in  1  serial key bit, LSB first
- key_ready  out  1  key bit accepted when key_valid & key_ready
- key_done  out  1  one-cycle pulse after the last key bit is accepted
- armed  out  1  key loaded, stream enabled
- in_valid  in  1  input data valid
- in_data  in  DATA_W  input data
- in_ready  out  1  input accepted when in_valid & in_ready
- out_valid  out  1  output valid
- out_data  out  DATA_W  keyed output
- out_ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; key register is all zeros; bit counter is 0.
  - All pipeline valid bits are 0 and all pipeline data is 0.
  - Outputs: key_ready=0, key_done=0, armed=0, in_ready=0, out_valid=0, out_data=0.
- FSM states: IDLE, LOAD, ARMED, DRAIN.
  - IDLE -> LOAD on key_start.
  - LOAD: key_ready=1. Each accepted bit is written to key_reg[cnt] and cnt increments.
    - When the bit with cnt==KEY_W-1 is accepted: cnt resets to 0, key_done pulses the next cycle, and the state moves to ARMED.
    - key_start in LOAD restarts the load: cnt=0, and the bit presented in that same cycle is ignored.
    - key_reg keeps partially written bits; unwritten positions keep their old values.
  - ARMED: armed=1 and the stream flows.
    - key_start moves to DRAIN.
    - in_ready drops in the same cycle key_start is sampled (combinational on key_start).
  - DRAIN: in_ready=0 while the pipeline empties.
    - When all stage valids are 0: go to LOAD (key_ready=1 from the next cycle).
    - key_start held during DRAIN has no extra effect.
- Key mask: effective bit i = key_reg[i mod KEY_W] ^ KEY_POL[i mod KEY_W] ^ 1, applied as out = in ^ ~effective.
  - Net result: out_data[i] = in_data[i] ^ key_reg[i mod KEY_W] ^ KEY_POL[i mod KEY_W].
  - A correct key gives identity.
  - The mask is applied at stage-1 capture. Data already in flight is never re-keyed.
- Pipeline: elastic, with per-stage valid.
  - Stage k advances when it is empty or when the next stage advances. The last stage advances when out_ready=1.
  - in_ready = (state==ARMED) & ~key_start & stage1 can accept.
  - Latency from accepted input to out_valid is STAGES cycles, with no bubbles at full throughput (1 word/cycle).
  - out_data holds stable while out_valid & ~out_ready (no drop, no duplicate).
- Boundaries:
  - KEY_W==DATA_W: key bits map 1:1 onto data bits.
  - KEY_W<DATA_W: key bits repeat across the data word (mod mapping).
  - key_valid outside LOAD is ignored.
  - Reset mid-LOAD or mid-DRAIN returns to IDLE and clears key_reg. In-flight data is discarded with out_valid=0.

Test Plan:
- Reset, then load 32 bits of KEY_POL=0 (all 0) with DATA_W=32, STAGES=2. Send 32'hDEAD_BEEF -> key_done pulses once, armed=1, out_data=32'hDEAD_BEEF exactly 2 cycles after acceptance.
- Same setup, load key 32'h0000_00FF. Send 32'h1234_5678 -> out_data=32'h1234_5687.
- KEY_POL=32'hA5A5_A5A5, load key 32'hA5A5_A5A5. Stream 8 words back-to-back with out_ready=1 -> outputs equal inputs, one per cycle, no bubbles.
- Hold out_ready=0 for 5 cycles with a full pipeline -> out_data stable, in_ready=0 after both stages fill. Release -> all words appear in order, none lost.
- key_start while 2 words are in flight -> DRAIN completes after both words exit with the old key mask. Then LOAD, key_ready=1. New key applies only to words accepted after key_done.
- KEY_W=8, DATA_W=32, key 8'h01, KEY_POL=0. Send 0 -> out_data=32'h0101_0101.
- Assert rst during LOAD bit 10 -> armed=0, out_valid=0. A new load is required before in_ready=1.
